// File: rtl/nn_layer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nn_pkg
// Description : Shared constants for the two-layer network sequencer:
//               layer sizes, default result widths and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    // Operand widths of the neuron datapath and fan-in of each layer
    localparam int c_IN_W = 8;
    localparam int c_WT_W = 8;
    localparam int c_M1   = 11;
    localparam int c_M2   = 2;

    // Neuron count per layer
    localparam int c_N1 = 2;
    localparam int c_N2 = 6;

    // Accumulator widths: product width plus growth for M inputs and the bias
    localparam int c_RES_W1 = c_IN_W + c_WT_W + $clog2(c_M1 + 1);
    localparam int c_RES_W2 = c_RES_W1 + c_WT_W + $clog2(c_M2 + 1);

    // Sequencer FSM encoding
    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE     = 3'd0;
    localparam state_t c_ST_L1_ISSUE = 3'd1;
    localparam state_t c_ST_L1_WAIT  = 3'd2;
    localparam state_t c_ST_L2_ISSUE = 3'd3;
    localparam state_t c_ST_L2_WAIT  = 3'd4;
    localparam state_t c_ST_DONE     = 3'd5;

endpackage
`default_nettype wire

// File: rtl/nn_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : nn_layer_sequencer_if
// Description : Issue/result handshake and layer-2 activation bus between
//               the sequencer (master) and the shared neuron datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface nn_layer_sequencer_if
    import nn_pkg::*;
#(
    parameter int N1     = c_N1,
    parameter int RES_W1 = c_RES_W1,
    parameter int RES_W2 = c_RES_W2,
    parameter int IDX_W  = 3
);

    logic                 issue;
    logic                 issue_layer;
    logic [IDX_W-1:0]     issue_idx;
    logic                 res_valid;
    logic [RES_W2-1:0]    res_data;
    logic [N1*RES_W1-1:0] act_l2;

    modport master (
        output issue, issue_layer, issue_idx, act_l2,
        input  res_valid, res_data
    );

    modport slave (
        input  issue, issue_layer, issue_idx, act_l2,
        output res_valid, res_data
    );

endinterface
`default_nettype wire

// File: rtl/nn_layer_sequencer_argmax.sv
`default_nettype none
// ============================================================================
// Module      : nn_argmax_tracker
// Description : Running maximum / argument register pair. i_first forces a
//               load so the first candidate seeds the search; afterwards a
//               candidate wins only if strictly greater, so ties keep the
//               earlier (lower) index.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_argmax_tracker #(
    parameter int VAL_W = 30,
    parameter int IDX_W = 3
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_clr,
    input  wire              i_upd,
    input  wire              i_first,
    input  wire [VAL_W-1:0]  i_val,
    input  wire [IDX_W-1:0]  i_idx,
    output logic [VAL_W-1:0] o_max_val,
    output logic [IDX_W-1:0] o_max_idx
);

    logic [VAL_W-1:0] r_max;
    logic [IDX_W-1:0] r_arg;
    logic             w_take;

    assign w_take = i_upd && (i_first || (i_val > r_max));

    // Hold the best value seen so far and the index that produced it
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_max <= '0;
            r_arg <= '0;
        end else if (w_take) begin
            r_max <= i_val;
            r_arg <= i_idx;
        end
    end

    assign o_max_val = r_max;
    assign o_max_idx = r_arg;

endmodule
`default_nettype wire

// File: rtl/nn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nn_layer_sequencer
// Description : Time-multiplexes one shared neuron datapath over the whole
//               two-layer network: N1 layer-1 evaluations whose results are
//               buffered as the layer-2 activation vector, then N2 layer-2
//               evaluations reduced by a running argmax into class_idx.
//               Optional macro NN_SEQ_WDOG_EN adds a per-evaluation watchdog
//               that aborts the inference (err + done, class unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int N1          = c_N1,
    parameter int N2          = c_N2,
    parameter int RES_W1      = c_RES_W1,
    parameter int RES_W2      = c_RES_W2,
    parameter int IDX_W       = 3,
    parameter int WDOG_CYCLES = 64
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   start,
    output logic                  busy,
    nn_layer_sequencer_if.master  dp,
    output logic                  done,
    output logic [IDX_W-1:0]      class_idx,
    output logic [RES_W2-1:0]     class_val,
    output logic                  err
);

    localparam logic [IDX_W-1:0] c_L1_LAST = IDX_W'(N1 - 1);
    localparam logic [IDX_W-1:0] c_L2_LAST = IDX_W'(N2 - 1);
    localparam logic [IDX_W-1:0] c_ONE     = IDX_W'(1);

    // Reject configurations the datapath cannot represent
    generate
        if (RES_W1 > RES_W2) begin : g_bad_res_w
            $error("nn_layer_sequencer: RES_W1 must not exceed RES_W2");
        end
        if (((1 << IDX_W) < N1) || ((1 << IDX_W) < N2) || (WDOG_CYCLES < 2)) begin : g_bad_cfg
            $error("nn_layer_sequencer: IDX_W too narrow or WDOG_CYCLES too small");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_class_idx;
    logic [RES_W2-1:0]    r_class_val;
    logic                 r_err;
    logic                 w_busy;
    logic                 w_issue;
    logic                 w_issue_layer;
    logic [IDX_W-1:0]     w_issue_idx;
    logic                 w_done;
    logic                 w_in_wait;
    logic                 w_start_acc;
    logic                 w_wdog_expire;
    logic                 w_skip_load;
    logic [RES_W2-1:0]    w_max_val;
    logic [IDX_W-1:0]     w_max_idx;
    wire  [N1*RES_W1-1:0] w_act;

    assign w_in_wait   = (r_state == c_ST_L1_WAIT) || (r_state == c_ST_L2_WAIT);
    assign w_start_acc = (r_state == c_ST_IDLE) && start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:     if (start) w_state_next = c_ST_L1_ISSUE;
            c_ST_L1_ISSUE: w_state_next = c_ST_L1_WAIT;
            c_ST_L1_WAIT: begin
                if (dp.res_valid) begin
                    w_state_next = (r_cnt == c_L1_LAST) ? c_ST_L2_ISSUE : c_ST_L1_ISSUE;
                end else if (w_wdog_expire) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_L2_ISSUE: w_state_next = c_ST_L2_WAIT;
            c_ST_L2_WAIT: begin
                if (dp.res_valid) begin
                    w_state_next = (r_cnt == c_L2_LAST) ? c_ST_DONE : c_ST_L2_ISSUE;
                end else if (w_wdog_expire) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE:     w_state_next = c_ST_IDLE;
            default:       w_state_next = c_ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        w_busy        = (r_state != c_ST_IDLE);
        w_issue       = (r_state == c_ST_L1_ISSUE) || (r_state == c_ST_L2_ISSUE);
        w_issue_layer = (r_state == c_ST_L2_ISSUE);
        w_issue_idx   = w_issue ? r_cnt : '0;
        w_done        = (r_state == c_ST_DONE);
    end

    // Neuron counter, sticky error and published class result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_class_idx <= '0;
            r_class_val <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end
                end
                c_ST_L1_WAIT: begin
                    if (dp.res_valid) begin
                        r_cnt <= (r_cnt == c_L1_LAST) ? '0 : r_cnt + c_ONE;
                    end
                end
                c_ST_L2_WAIT: begin
                    if (dp.res_valid && (r_cnt != c_L2_LAST)) begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                c_ST_DONE: begin
                    if (!w_skip_load) begin
                        r_class_idx <= w_max_idx;
                        r_class_val <= w_max_val;
                    end
                end
                default: ;
            endcase
            // A result strobe outside a wait window is a protocol error
            if ((dp.res_valid && !w_in_wait) || w_wdog_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    // Layer-1 result buffer, one slot per layer-1 neuron; kept across start
    generate
        for (genvar gi = 0; gi < N1; gi++) begin : g_slot
            logic [RES_W1-1:0] r_slot;

            // Capture the truncated layer-1 result addressed by the counter
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot <= '0;
                end else if ((r_state == c_ST_L1_WAIT) && dp.res_valid && (r_cnt == IDX_W'(gi))) begin
                    r_slot <= dp.res_data[RES_W1-1:0];
                end
            end

            assign w_act[gi*RES_W1 +: RES_W1] = r_slot;
        end
    endgenerate

`ifdef NN_SEQ_WDOG_EN
    localparam int c_WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WDOG_CYCLES - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

    logic [c_WD_W-1:0] r_wdog;
    logic              r_timeout;

    // Idle-cycle counter per evaluation; a timeout suppresses the class load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_issue) begin
                r_wdog <= '0;
            end else if (w_in_wait && !dp.res_valid) begin
                r_wdog <= r_wdog + c_WD_ONE;
            end
            if (w_start_acc) begin
                r_timeout <= 1'b0;
            end else if (w_wdog_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_wdog_expire = w_in_wait && !dp.res_valid && (r_wdog == c_WD_LAST);
    assign w_skip_load   = r_timeout;
`else
    assign w_wdog_expire = 1'b0;
    assign w_skip_load   = 1'b0;
`endif

    nn_argmax_tracker #(
        .VAL_W (RES_W2),
        .IDX_W (IDX_W)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_start_acc),
        .i_upd     ((r_state == c_ST_L2_WAIT) && dp.res_valid),
        .i_first   (r_cnt == '0),
        .i_val     (dp.res_data),
        .i_idx     (r_cnt),
        .o_max_val (w_max_val),
        .o_max_idx (w_max_idx)
    );

    assign busy           = w_busy;
    assign done           = w_done;
    assign err            = r_err;
    assign class_idx      = r_class_idx;
    assign class_val      = r_class_val;
    assign dp.issue       = w_issue;
    assign dp.issue_layer = w_issue_layer;
    assign dp.issue_idx   = w_issue_idx;
    assign dp.act_l2      = w_act;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_layer_sequencer
// Description : Self-checking bench for nn_layer_sequencer: table vectors,
//               randomized inferences against a reference model, and
//               hand-written reset / spurious-strobe / watchdog sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_layer_sequencer;

    localparam int c_N1 = 2;
    localparam int c_N2 = 6;
    localparam int c_W1 = 20;
    localparam int c_W2 = 30;
    localparam int c_IW = 3;
    localparam int c_WD = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [c_IW-1:0]   class_idx;
    logic [c_W2-1:0]   class_val;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [c_IW-1:0] g_last_idx;
    logic [c_W2-1:0] g_last_val;

    nn_layer_sequencer_if #(.N1(c_N1), .RES_W1(c_W1), .RES_W2(c_W2), .IDX_W(c_IW)) dp_if ();

    nn_layer_sequencer #(
        .N1(c_N1), .N2(c_N2), .RES_W1(c_W1), .RES_W2(c_W2), .IDX_W(c_IW), .WDOG_CYCLES(c_WD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .dp        (dp_if),
        .done      (done),
        .class_idx (class_idx),
        .class_val (class_val),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0][29:0] l1;
        logic [5:0][29:0] l2;
        int               lat;
        bit               noise;
        logic [39:0]      exp_act;
        logic [2:0]       exp_idx;
        logic [29:0]      exp_val;
        int               exp_cyc;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_issue(inout int cyc, output bit ok);
        int n = 0;
        while (!dp_if.issue && n < 50) begin
            @(negedge clk);
            cyc++;
            n++;
        end
        ok = dp_if.issue;
    endtask

    // Reference: max value first, then the lowest index holding it
    function automatic void model(input logic [5:0][29:0] l2, output logic [2:0] idx, output logic [29:0] mx);
        mx = '0;
        for (int i = 0; i < 6; i++) if (l2[i] > mx) mx = l2[i];
        idx = '0;
        for (int i = 5; i >= 0; i--) if (l2[i] == mx) idx = 3'(i);
    endfunction

    task automatic run_inf(input string tag, input logic [1:0][29:0] l1, input logic [5:0][29:0] l2,
                           input logic [7:0][3:0] lat, input bit noise, input logic [39:0] exp_act,
                           input logic [2:0] exp_idx, input logic [29:0] exp_val, input int exp_cyc);
        int cyc;
        int n;
        bit ok;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk({tag, " busy_after_start"}, busy, 1);
        chk({tag, " err_cleared"}, err, 0);
        for (int k = 0; k < 8; k++) begin
            wait_issue(cyc, ok);
            if (!ok) begin
                chk({tag, " issue_timeout"}, dp_if.issue, 1);
                return;
            end
            chk({tag, " issue_layer"}, dp_if.issue_layer, (k >= 2) ? 1 : 0);
            chk({tag, " issue_idx"}, dp_if.issue_idx, (k < 2) ? k : k - 2);
            @(negedge clk);
            cyc++;
            for (int s = 1; s < int'(lat[k]); s++) begin
                if (noise) start = 1'b1;
                chk({tag, " no_reissue"}, dp_if.issue, 0);
                chk({tag, " busy_wait"}, busy, 1);
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            dp_if.res_valid = 1'b1;
            dp_if.res_data  = (k < 2) ? l1[k] : l2[k-2];
            @(negedge clk);
            cyc++;
            dp_if.res_valid = 1'b0;
            dp_if.res_data  = 30'($urandom);
        end
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            cyc++;
            n++;
        end
        chk({tag, " done_seen"}, done, 1);
        chk({tag, " done_cycle"}, cyc, exp_cyc);
        chk({tag, " busy_in_done"}, busy, 1);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done, 0);
        chk({tag, " busy_idle"}, busy, 0);
        chk({tag, " class_idx"}, class_idx, exp_idx);
        chk({tag, " class_val"}, class_val, exp_val);
        chk({tag, " act_l2"}, dp_if.act_l2, exp_act);
        chk({tag, " err_clean"}, err, 0);
        g_last_idx = exp_idx;
        g_last_val = exp_val;
    endtask

    initial begin
        logic [7:0][3:0]  lat;
        logic [1:0][29:0] l1;
        logic [5:0][29:0] l2;
        logic [2:0]       m_idx;
        logic [29:0]      m_val;
        int               cyc;
        bit               ok;

        tbl[0].l1 = {30'd9, 30'd5};
        tbl[0].l2 = {30'd1, 30'd6, 30'd2, 30'd7, 30'd7, 30'd3};
        tbl[0].lat = 1; tbl[0].noise = 0;
        tbl[0].exp_act = 40'h00009_00005; tbl[0].exp_idx = 3'd1; tbl[0].exp_val = 30'd7; tbl[0].exp_cyc = 17;

        tbl[1] = tbl[0];
        tbl[1].lat = 4; tbl[1].noise = 1; tbl[1].exp_cyc = 41;

        tbl[2].l1 = {30'd2, 30'd1};
        tbl[2].l2 = '0;
        tbl[2].lat = 1; tbl[2].noise = 0;
        tbl[2].exp_act = 40'h00002_00001; tbl[2].exp_idx = 3'd0; tbl[2].exp_val = 30'd0; tbl[2].exp_cyc = 17;

        tbl[3].l1 = {30'h2D0ABCDE, 30'h3FF12345};
        tbl[3].l2 = {30'd100, 30'd5, 30'd4, 30'd3, 30'd2, 30'd1};
        tbl[3].lat = 2; tbl[3].noise = 0;
        tbl[3].exp_act = 40'hABCDE_12345; tbl[3].exp_idx = 3'd5; tbl[3].exp_val = 30'd100; tbl[3].exp_cyc = 25;

        rst = 1'b1;
        start = 1'b0;
        dp_if.res_valid = 1'b0;
        dp_if.res_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst issue", dp_if.issue, 0);
        chk("rst issue_layer", dp_if.issue_layer, 0);
        chk("rst issue_idx", dp_if.issue_idx, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst class_idx", class_idx, 0);
        chk("rst class_val", class_val, 0);
        chk("rst act_l2", dp_if.act_l2, 0);

        // Strobe while idle: flags err, no state change
        @(negedge clk);
        dp_if.res_valid = 1'b1;
        dp_if.res_data  = 30'd77;
        @(negedge clk);
        dp_if.res_valid = 1'b0;
        chk("idle_strobe err", err, 1);
        chk("idle_strobe busy", busy, 0);
        chk("idle_strobe act_l2", dp_if.act_l2, 0);

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 8; k++) lat[k] = 4'(tbl[v].lat);
            run_inf($sformatf("tbl%0d", v), tbl[v].l1, tbl[v].l2, lat, tbl[v].noise,
                    tbl[v].exp_act, tbl[v].exp_idx, tbl[v].exp_val, tbl[v].exp_cyc);
        end

        // Reset in the middle of layer 2
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 2; k++) begin
            wait_issue(cyc, ok);
            @(negedge clk);
            dp_if.res_valid = 1'b1;
            dp_if.res_data  = 30'(k + 40);
            @(negedge clk);
            dp_if.res_valid = 1'b0;
        end
        wait_issue(cyc, ok);
        chk("midrst l2_issue", dp_if.issue_layer, 1);
        @(negedge clk);
        chk("midrst busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst class_idx", class_idx, 0);
        chk("midrst class_val", class_val, 0);
        chk("midrst act_l2", dp_if.act_l2, 0);
        dp_if.res_valid = 1'b1;
        dp_if.res_data  = 30'd123;
        @(negedge clk);
        dp_if.res_valid = 1'b0;
        chk("late_strobe act_l2", dp_if.act_l2, 0);
        chk("late_strobe busy", busy, 0);
        chk("late_strobe class_val", class_val, 0);

        // Randomized inferences against the reference model
        for (int r = 0; r < 16; r++) begin
            int exp_cyc;
            exp_cyc = 1;
            for (int k = 0; k < 8; k++) begin
                lat[k] = 4'($urandom_range(1, 5));
                exp_cyc += 1 + int'(lat[k]);
            end
            for (int k = 0; k < 2; k++) l1[k] = 30'($urandom);
            for (int k = 0; k < 6; k++) l2[k] = ($urandom_range(0, 1) == 1) ? 30'($urandom_range(0, 3)) : 30'($urandom);
            model(l2, m_idx, m_val);
            run_inf($sformatf("rnd%0d", r), l1, l2, lat, bit'($urandom_range(0, 1)),
                    {l1[1][19:0], l1[0][19:0]}, m_idx, m_val, exp_cyc);
        end

`ifdef NN_SEQ_WDOG_EN
        begin
            int t_issue;
            int n;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 1;
            for (int k = 0; k < 2; k++) begin
                wait_issue(cyc, ok);
                @(negedge clk);
                cyc++;
                dp_if.res_valid = 1'b1;
                dp_if.res_data  = 30'(k + 3);
                @(negedge clk);
                cyc++;
                dp_if.res_valid = 1'b0;
            end
            wait_issue(cyc, ok);
            t_issue = cyc;
            n = 0;
            while (!done && n < 200) begin
                @(negedge clk);
                cyc++;
                n++;
            end
            chk("wdog done", done, 1);
            chk("wdog latency_ok", ((cyc - t_issue) >= c_WD) && ((cyc - t_issue) <= c_WD + 2), 1);
            chk("wdog err", err, 1);
            chk("wdog class_idx_at_done", class_idx, g_last_idx);
            @(negedge clk);
            chk("wdog idle", busy, 0);
            chk("wdog class_idx_kept", class_idx, g_last_idx);
            chk("wdog class_val_kept", class_val, g_last_val);
            chk("wdog err_sticky", err, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
